// File: rtl/int_to_float_enc.sv
// Converts a 16-bit signed integer to a 16-bit float {sign, exp[3:0], man[10:0]}
// by shifting the magnitude left one bit per cycle until its MSB is set (truncating).
module int_to_float_enc (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_inexact
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // in_ready is high only in IDLE, out_valid only in DONE, and DONE holds until out_ready.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_q;
  logic        sign_q;
  logic [15:0] m_q;
  logic [3:0]  exp_q;
  logic        out_valid_q;
  logic [15:0] out_data_q;
  logic        out_inexact_q;

  logic [15:0] mag_d;
  logic        norm_done_d;

  // 0x8000 negates to itself, which is exactly the 16-bit unsigned magnitude wanted.
  assign mag_d       = in_data[15] ? 16'(~in_data + 16'd1) : in_data;
  assign norm_done_d = m_q[15] || (m_q == 16'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      sign_q        <= 1'b0;
      m_q           <= 16'd0;
      exp_q         <= 4'd0;
      out_valid_q   <= 1'b0;
      out_data_q    <= 16'd0;
      out_inexact_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sign_q  <= in_data[15];
            m_q     <= mag_d;
            exp_q   <= 4'd15;
            state_q <= NORM;
          end
        end
        NORM: begin
          if (norm_done_d) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            if (m_q == 16'd0) begin
              // Zero always encodes as +0, whatever the input sign was.
              out_data_q    <= 16'd0;
              out_inexact_q <= 1'b0;
            end else begin
              out_data_q    <= {sign_q, exp_q, m_q[14:4]};
              out_inexact_q <= |m_q[3:0];
            end
          end else begin
            m_q   <= {m_q[14:0], 1'b0};
            exp_q <= exp_q - 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_inexact = out_inexact_q;

endmodule

// File: tb/tb_int_to_float_enc.sv
// Bench for int_to_float_enc: hand-written vector table, randomized values against an
// arithmetic reference model, backpressure and mid-conversion reset sequences.
module tb_int_to_float_enc;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_inexact;

  int n_vec = 0;
  int n_err = 0;

  int_to_float_enc dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_inexact (out_inexact)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [15:0] din;
    logic [15:0] dout;
    logic        inex;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: value = 1.man * 2^p with man the 11 fraction bits below the leading one.
  function automatic void model(input logic [15:0] din, output logic [15:0] dout,
                                output logic inex, output int lat);
    int v;
    int m;
    int p;
    int scaled;
    int man;
    v = int'(shortint'(din));
    m = (v < 0) ? -v : v;
    if (m == 0) begin
      dout = 16'h0000;
      inex = 1'b0;
      lat  = 1;
    end else begin
      p = 0;
      while ((1 << (p + 1)) <= m) p++;
      scaled = (m - (1 << p)) * 2048;
      man    = scaled / (1 << p);
      inex   = (scaled % (1 << p)) != 0;
      dout   = {din[15], 4'(p), 11'(man)};
      lat    = 16 - p;
    end
  endfunction

  // driver: send one value, measure latency, hold output for `hold` cycles, retire it
  task automatic run_vec(input logic [15:0] din, input logic [15:0] edata,
                         input logic einex, input int elat, input int hold);
    int lat;
    int w;
    w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("in_ready_idle", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = din;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 16'($urandom);
    check("in_ready_busy", {31'd0, in_ready}, 32'd0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(elat));
    check("out_data", {16'd0, out_data}, {16'd0, edata});
    check("out_inexact", {31'd0, out_inexact}, {31'd0, einex});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 16'($urandom);
      @(posedge clk);
      #1;
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_data", {16'd0, out_data}, {16'd0, edata});
      check("hold_ready", {31'd0, in_ready}, 32'd0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("retire_valid", {31'd0, out_valid}, 32'd0);
    check("retire_ready", {31'd0, in_ready}, 32'd1);
    check("retire_keep", {16'd0, out_data}, {16'd0, edata});
  endtask

  vec_t tbl[$];

  initial begin
    logic [15:0] d;
    logic [15:0] ed;
    logic        ei;
    int          el;

    tbl.push_back('{16'h0005, 16'h1200, 1'b0, 14});
    tbl.push_back('{16'hFFFB, 16'h9200, 1'b0, 14});
    tbl.push_back('{16'h8000, 16'hF800, 1'b0, 1});
    tbl.push_back('{16'h7FFF, 16'h77FF, 1'b1, 2});
    tbl.push_back('{16'h0001, 16'h0000, 1'b0, 16});
    tbl.push_back('{16'h0000, 16'h0000, 1'b0, 1});
    tbl.push_back('{16'hFFFF, 16'h8000, 1'b0, 16});
    tbl.push_back('{16'h1234, 16'h611A, 1'b0, 4});
    tbl.push_back('{16'h0FFF, 16'h5FFF, 1'b0, 5});
    tbl.push_back('{16'h0100, 16'h4000, 1'b0, 8});

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 16'h0;
    out_ready = 1'b0;
    #12;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data", {16'd0, out_data}, 32'd0);
    check("rst_inexact", {31'd0, out_inexact}, 32'd0);
    check("rst_ready", {31'd0, in_ready}, 32'd1);

    // first accept lands on the first rising edge after reset release
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < tbl.size(); i++)
      run_vec(tbl[i].din, tbl[i].dout, tbl[i].inex, tbl[i].lat, (i == 0) ? 5 : 0);

    for (int i = 0; i < 60; i++) begin
      d = 16'($urandom);
      if (i % 10 == 0) d = 16'($urandom_range(0, 15));
      model(d, ed, ei, el);
      run_vec(d, ed, ei, el, $urandom_range(0, 3));
    end

    // reset in the middle of normalisation abandons the conversion
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 16'h0001;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_data", {16'd0, out_data}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      check("mid_rst_quiet", {31'd0, out_valid}, 32'd0);
    end
    run_vec(16'h0100, 16'h4000, 1'b0, 8, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
